// File: rtl/tetris_pkg.sv
// Shared Tetris constants: playfield geometry, coordinate widths and the
// line-clear FSM state encoding. Imported by board_mem and gamelogic.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int X_W     = 4;
    localparam int Y_W     = 5;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_SCAN = 2'd1,
        C_DONE = 2'd2
    } clear_state_t;

    // True when (x, y) addresses a real playfield cell.
    function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < X_W'(BOARD_W)) && (y < Y_W'(BOARD_H));
    endfunction

endpackage

// File: rtl/board_mem_if.sv
// Board port bundle: game read port, renderer read port, single-cell write
// port and the line-clear start/busy/done handshake.
interface board_mem_if;
    import tetris_pkg::*;

    logic [X_W-1:0]   board_rx;
    logic [Y_W-1:0]   board_ry;
    logic             board_rdata;
    logic [X_W-1:0]   vga_rx;
    logic [Y_W-1:0]   vga_ry;
    logic             vga_rdata;
    logic             board_we;
    logic [X_W-1:0]   board_wx;
    logic [Y_W-1:0]   board_wy;
    logic             board_wdata;
    logic             clear_start;
    logic             clear_busy;
    logic             clear_done;
    logic [CNT_W-1:0] lines_cleared;

    modport master (
        output board_rx, board_ry, vga_rx, vga_ry,
        output board_we, board_wx, board_wy, board_wdata, clear_start,
        input  board_rdata, vga_rdata, clear_busy, clear_done, lines_cleared
    );

    modport slave (
        input  board_rx, board_ry, vga_rx, vga_ry,
        input  board_we, board_wx, board_wy, board_wdata, clear_start,
        output board_rdata, vga_rdata, clear_busy, clear_done, lines_cleared
    );

endinterface

// File: rtl/board_line_clear.sv
// Line-clear sequencer. Scans rows bottom-up one per cycle; when the row under
// the pointer is full it requests a shift-down of everything above it and
// re-checks the same row, since a full row may have dropped into place.
module board_line_clear
    import tetris_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_start,
    input  logic [BOARD_H-1:0] row_full,
    output logic             shift_en,
    output logic [Y_W-1:0]   shift_row,
    output logic             clear_busy,
    output logic             clear_done,
    output logic [CNT_W-1:0] lines_cleared
);

    clear_state_t     state_q, state_d;
    logic [Y_W-1:0]   r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State, row pointer and cleared-line counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
            r_q     <= Y_W'(BOARD_H - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and shift request for the array owner.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        shift_en  = 1'b0;
        shift_row = r_q;
        case (state_q)
            C_IDLE: begin
                if (clear_start) begin
                    r_d     = Y_W'(BOARD_H - 1);
                    cnt_d   = '0;
                    state_d = C_SCAN;
                end
            end
            C_SCAN: begin
                if (row_full[r_q]) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end else if (r_q == '0) begin
                    state_d = C_DONE;
                end else begin
                    r_d = r_q - Y_W'(1);
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    assign clear_busy    = (state_q != C_IDLE);
    assign clear_done    = (state_q == C_DONE);
    assign lines_cleared = cnt_q;

endmodule

// File: rtl/board_mem.sv
// 10x20 occupancy store: two combinational read ports (game, renderer), a
// single-cell write port locked out during a clear, and the row-shift datapath
// driven by the line-clear sequencer.
module board_mem
    import tetris_pkg::*;
(
    input  logic     CLOCK_50,
    input  logic     resetn,
    board_mem_if.slave bus
);

    logic [BOARD_W-1:0] rows_q    [BOARD_H];
    logic [BOARD_W-1:0] rows_d    [BOARD_H];
    logic [BOARD_W-1:0] above_row [BOARD_H];
    logic [BOARD_H-1:0] row_full;
    logic               shift_en;
    logic [Y_W-1:0]     shift_row;
    logic               clear_busy;
    logic               clear_done;
    logic [CNT_W-1:0]   lines_cleared;
    logic               board_rd;
    logic               vga_rd;

    // Per-row full detect and the row that slides into each slot on a shift;
    // the top row is refilled with empty cells.
    for (genvar gi = 0; gi < BOARD_H; gi++) begin : g_row
        assign row_full[gi] = &rows_q[gi];
        if (gi == 0) begin : g_top
            assign above_row[gi] = '0;
        end else begin : g_below
            assign above_row[gi] = rows_q[gi-1];
        end
    end

    board_line_clear u_clear (
        .clk          (CLOCK_50),
        .rst_n        (resetn),
        .clear_start  (bus.clear_start),
        .row_full     (row_full),
        .shift_en     (shift_en),
        .shift_row    (shift_row),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .lines_cleared(lines_cleared)
    );

    // Next array contents: shift rows 0..shift_row down by one, else apply a write.
    always_comb begin
        rows_d = rows_q;
        if (shift_en) begin
            for (int k = 0; k < BOARD_H; k++) begin
                if (Y_W'(k) <= shift_row) begin
                    rows_d[k] = above_row[k];
                end
            end
        end else if (bus.board_we && !clear_busy && in_range(bus.board_wx, bus.board_wy)) begin
            rows_d[bus.board_wy][bus.board_wx] = bus.board_wdata;
        end
    end

    // Row registers; reset empties the playfield.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < BOARD_H; k++) begin
                rows_q[k] <= '0;
            end
        end else begin
            rows_q <= rows_d;
        end
    end

    // Read muxes; anything off the board reads as occupied so walls and floor collide.
    always_comb begin
        board_rd = 1'b1;
        vga_rd   = 1'b1;
        if (in_range(bus.board_rx, bus.board_ry)) begin
            board_rd = rows_q[bus.board_ry][bus.board_rx];
        end
        if (in_range(bus.vga_rx, bus.vga_ry)) begin
            vga_rd = rows_q[bus.vga_ry][bus.vga_rx];
        end
    end

    assign bus.board_rdata   = board_rd;
    assign bus.vga_rdata     = vga_rd;
    assign bus.clear_busy    = clear_busy;
    assign bus.clear_done    = clear_done;
    assign bus.lines_cleared = lines_cleared;

endmodule

// File: tb/tb_board_mem.sv
// Scoreboard bench for board_mem: stimulus pushes expected read/status values
// and expected clear completions into queues; a monitor on the falling edge
// pops and compares whenever a read is requested or clear_done is seen.
module tb_board_mem;
    import tetris_pkg::*;

    typedef enum int {K_BRD, K_VGA, K_BUSY, K_DONE, K_LINES} kind_t;
    typedef struct {
        string name;
        kind_t kind;
        int    exp;
    } chk_t;
    typedef struct {
        int lines;
        int start_cyc;
    } done_t;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;
    board_mem_if bus();

    board_mem dut (
        .CLOCK_50(CLOCK_50),
        .resetn  (resetn),
        .bus     (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int    cyc = 0;
    chk_t  cq[$];
    done_t dq[$];
    bit    rd_req = 1'b0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge CLOCK_50) cyc++;

    // Monitor: compare requested samples and every clear_done pulse.
    always @(negedge CLOCK_50) begin
        chk_t  c;
        done_t d;
        int    act;
        int    cyc_no;
        if (rd_req) begin
            if (cq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got sample request, required a queued expectation");
            end else begin
                c = cq.pop_front();
                case (c.kind)
                    K_BRD:   act = int'(bus.board_rdata);
                    K_VGA:   act = int'(bus.vga_rdata);
                    K_BUSY:  act = int'(bus.clear_busy);
                    K_DONE:  act = int'(bus.clear_done);
                    default: act = int'(bus.lines_cleared);
                endcase
                checks++;
                if (act != c.exp) begin
                    errors++;
                    $display("FAIL %s: got %0d required %0d", c.name, act, c.exp);
                end else begin
                    $display("ok   %s = %0d", c.name, act);
                end
            end
        end
        if (bus.clear_done === 1'b1) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got clear_done=1 at tb cycle %0d, required no pulse", cyc);
            end else begin
                d = dq.pop_front();
                cyc_no = cyc - d.start_cyc + 1;
                checks += 2;
                if (int'(bus.lines_cleared) != d.lines) begin
                    errors++;
                    $display("FAIL done_lines: got %0d required %0d", bus.lines_cleared, d.lines);
                end else begin
                    $display("ok   done_lines = %0d", d.lines);
                end
                if (cyc_no != 21 + d.lines) begin
                    errors++;
                    $display("FAIL done_cycle: got %0d required %0d", cyc_no, 21 + d.lines);
                end else begin
                    $display("ok   done_cycle = %0d", cyc_no);
                end
            end
        end
    end

    // Queue one expectation and request a sample on the coming falling edge.
    task automatic chk(input kind_t k, input int x, input int y, input int exp,
                       input string nm, input bit now = 1'b0);
        if (!now) begin
            @(posedge CLOCK_50);
            #1;
        end
        if (k == K_BRD) begin
            bus.board_rx = 4'(x);
            bus.board_ry = 5'(y);
        end
        if (k == K_VGA) begin
            bus.vga_rx = 4'(x);
            bus.vga_ry = 5'(y);
        end
        cq.push_back('{name: nm, kind: k, exp: exp});
        rd_req = 1'b1;
        @(negedge CLOCK_50);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic wr(input int x, input int y, input bit v);
        @(posedge CLOCK_50);
        #1;
        bus.board_we    = 1'b1;
        bus.board_wx    = 4'(x);
        bus.board_wy    = 5'(y);
        bus.board_wdata = v;
        @(posedge CLOCK_50);
        #1;
        bus.board_we = 1'b0;
    endtask

    task automatic start_clear(input int lines, input bit expect_done);
        @(posedge CLOCK_50);
        #1;
        bus.clear_start = 1'b1;
        if (expect_done) dq.push_back('{lines: lines, start_cyc: cyc + 1});
        @(posedge CLOCK_50);
        #1;
        bus.clear_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80 && dq.size() != 0; i++) @(posedge CLOCK_50);
        if (dq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no clear_done within 80 cycles, required one");
            dq.delete();
        end
    endtask

    initial begin
        bus.board_rx = '0; bus.board_ry = '0;
        bus.vga_rx = '0;   bus.vga_ry = '0;
        bus.board_we = 1'b0; bus.board_wx = '0; bus.board_wy = '0; bus.board_wdata = 1'b0;
        bus.clear_start = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        resetn = 1'b1;

        // Reset state and out-of-range reads
        chk(K_BUSY, 0, 0, 0, "reset_busy");
        chk(K_DONE, 0, 0, 0, "reset_done");
        chk(K_LINES, 0, 0, 0, "reset_lines");
        chk(K_BRD, 0, 0, 0, "rd_0_0");
        chk(K_BRD, 9, 19, 0, "rd_9_19");
        chk(K_BRD, 10, 5, 1, "rd_wall_10_5");
        chk(K_BRD, 3, 20, 1, "rd_floor_3_20");
        chk(K_BRD, 15, 0, 1, "rd_wrap_15_0");
        chk(K_VGA, 0, 0, 0, "vga_0_0");
        chk(K_VGA, 15, 3, 1, "vga_wrap_15_3");

        // Writes, including an out-of-range one that must not alias
        wr(4, 19, 1'b1);
        chk(K_BRD, 4, 19, 1, "wr_4_19");
        chk(K_VGA, 4, 19, 1, "vga_4_19");
        wr(12, 3, 1'b1);
        chk(K_BRD, 2, 3, 0, "oor_wr_2_3");
        chk(K_BRD, 2, 4, 0, "oor_wr_2_4");

        // Two full rows plus a stray cell above them
        for (int x = 0; x < BOARD_W; x++) begin
            wr(x, 19, 1'b1);
            wr(x, 18, 1'b1);
        end
        wr(2, 17, 1'b1);
        start_clear(2, 1'b1);
        chk(K_BUSY, 0, 0, 1, "busy_after_start", 1'b1);
        wait_done();
        chk(K_BUSY, 0, 0, 0, "busy_after_done");
        chk(K_LINES, 0, 0, 2, "lines_two");
        chk(K_BRD, 2, 19, 1, "dropped_2_19");
        chk(K_BRD, 4, 19, 0, "cleared_4_19");
        chk(K_BRD, 2, 17, 0, "empty_2_17");
        for (int x = 0; x < BOARD_W; x += 3) chk(K_VGA, x, 18, 0, $sformatf("empty_%0d_18", x));

        // Writing 0 clears a cell; then clear a full top row
        wr(2, 19, 1'b0);
        chk(K_BRD, 2, 19, 0, "wr_zero_2_19");
        for (int x = 0; x < BOARD_W; x++) wr(x, 0, 1'b1);
        chk(K_BRD, 5, 0, 1, "row0_filled");
        start_clear(1, 1'b1);
        wait_done();
        chk(K_LINES, 0, 0, 1, "lines_one");
        chk(K_BRD, 0, 0, 0, "row0_empty_0");
        chk(K_BRD, 9, 0, 0, "row0_empty_9");

        // Write and a second start while busy are both ignored
        start_clear(0, 1'b1);
        wr(0, 0, 1'b1);
        start_clear(0, 1'b0);
        wait_done();
        chk(K_BRD, 0, 0, 0, "busy_write_ignored");
        repeat (30) @(posedge CLOCK_50);
        chk(K_BUSY, 0, 0, 0, "no_restart");
        chk(K_LINES, 0, 0, 0, "lines_zero");

        // Reset in the middle of a scan
        for (int x = 0; x < BOARD_W; x++) begin
            wr(x, 19, 1'b1);
            wr(x, 18, 1'b1);
        end
        wr(3, 10, 1'b1);
        start_clear(0, 1'b0);
        repeat (4) @(posedge CLOCK_50);
        #1;
        resetn = 1'b0;
        chk(K_BUSY, 0, 0, 0, "rst_mid_busy", 1'b1);
        chk(K_DONE, 0, 0, 0, "rst_mid_done", 1'b1);
        chk(K_LINES, 0, 0, 0, "rst_mid_lines", 1'b1);
        chk(K_BRD, 3, 10, 0, "rst_mid_3_10", 1'b1);
        chk(K_VGA, 5, 19, 0, "rst_mid_5_19", 1'b1);
        @(posedge CLOCK_50);
        #1;
        resetn = 1'b1;
        repeat (30) @(posedge CLOCK_50);
        chk(K_BUSY, 0, 0, 0, "post_rst_idle");
        chk(K_BRD, 3, 10, 0, "post_rst_3_10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
